// File: rtl/corefifo_ptr_sync_nstage.sv
// N-stage synchronizer for gray-coded FIFO pointers entering the clk domain.
// Adds a gray-to-binary output, a per-update change strobe, and a gray integrity checker.
module corefifo_ptr_sync_nstage #(
    parameter int ADDRWIDTH   = 3,
    parameter int STAGES      = 2,
    parameter int CHK_GRAY    = 1,
    parameter int BIN_OUT_REG = 1,
    parameter int ERRCNT_W    = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ADDRWIDTH:0]  inp,
    input  logic                err_clr,
    output logic [ADDRWIDTH:0]  sync_out,
    output logic [ADDRWIDTH:0]  sync_bin,
    output logic                ptr_chg,
    output logic                gray_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int W = ADDRWIDTH + 1;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("corefifo_ptr_sync_nstage: STAGES must be in 2..4");
    end

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [STAGES-1:0][W-1:0] stage;
    logic [W-1:0]             sync_out_d;
    logic [W-1:0]             diff;
    logic                     chg;
    logic [W-1:0]             bin_comb;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage      <= '0;
            sync_out_d <= '0;
        end else begin
            stage      <= {stage[STAGES-2:0], inp};
            sync_out_d <= stage[STAGES-1];
        end
    end

    assign sync_out = stage[STAGES-1];
    assign diff     = sync_out ^ sync_out_d;
    assign chg      = (diff != '0);
    assign bin_comb = gray2bin(sync_out);

    if (BIN_OUT_REG != 0) begin : g_bin_reg
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync_bin <= '0;
                ptr_chg  <= 1'b0;
            end else begin
                sync_bin <= bin_comb;
                ptr_chg  <= chg;
            end
        end
    end else begin : g_bin_comb
        assign sync_bin = bin_comb;
        assign ptr_chg  = chg;
    end

    // A step is judged once, in the cycle sync_out differs from its history,
    // so a bad value that then holds is counted a single time.
    if (CHK_GRAY != 0) begin : g_chk
        logic viol;
        assign viol = ($countones(diff) > 1);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                gray_err <= 1'b0;
                err_cnt  <= '0;
            end else if (viol) begin
                gray_err <= 1'b1;
                if (err_clr) begin
                    err_cnt <= ERRCNT_W'(1);
                end else if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end else if (err_clr) begin
                gray_err <= 1'b0;
                err_cnt  <= '0;
            end
        end
    end else begin : g_no_chk
        assign gray_err = 1'b0;
        assign err_cnt  = '0;
    end

endmodule

// File: tb/tb_corefifo_ptr_sync_nstage.sv
// Bench for corefifo_ptr_sync_nstage: two configurations driven in parallel,
// expected outputs queued at drive time and compared at the following negedge.
module tb_corefifo_ptr_sync_nstage;

    logic       clk = 1'b0;
    logic       rstn;
    logic       err_clr;
    logic [3:0] inp;

    logic [3:0] so_a, bin_a, so_b, bin_b;
    logic       chg_a, gerr_a, chg_b, gerr_b;
    logic [1:0] cnt_a;
    logic [7:0] cnt_b;

    corefifo_ptr_sync_nstage #(
        .ADDRWIDTH(3), .STAGES(2), .CHK_GRAY(1), .BIN_OUT_REG(1), .ERRCNT_W(2)
    ) u_a (
        .clk(clk), .rstn(rstn), .inp(inp), .err_clr(err_clr),
        .sync_out(so_a), .sync_bin(bin_a), .ptr_chg(chg_a),
        .gray_err(gerr_a), .err_cnt(cnt_a)
    );

    corefifo_ptr_sync_nstage #(
        .ADDRWIDTH(3), .STAGES(4), .CHK_GRAY(1), .BIN_OUT_REG(0), .ERRCNT_W(8)
    ) u_b (
        .clk(clk), .rstn(rstn), .inp(inp), .err_clr(err_clr),
        .sync_out(so_b), .sync_bin(bin_b), .ptr_chg(chg_b),
        .gray_err(gerr_b), .err_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] so;
        logic [3:0] bin;
        logic       chg;
        logic       gerr;
        int         cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: the pointer captured at each edge, newest first.
    logic [3:0] cap [2][8];
    int         m_gerr [2];
    int         m_cnt  [2];
    int         stg    [2] = '{2, 4};
    int         br     [2] = '{1, 0};
    int         cmax   [2] = '{3, 255};

    bit count_en = 1'b0;
    int pulses_a = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic model_step(input int d, input logic [3:0] in_v, input logic clr_v,
                              input logic rst_v, output exp_t e);
        int  s;
        bit  viol;
        s = stg[d];
        if (!rst_v) begin
            for (int i = 0; i < 8; i++) cap[d][i] = 4'h0;
            m_gerr[d] = 0;
            m_cnt[d]  = 0;
        end else begin
            viol = ($countones(cap[d][s-1] ^ cap[d][s]) >= 2);
            if (viol) begin
                m_gerr[d] = 1;
                if (clr_v) m_cnt[d] = 1;
                else if (m_cnt[d] < cmax[d]) m_cnt[d] = m_cnt[d] + 1;
            end else if (clr_v) begin
                m_gerr[d] = 0;
                m_cnt[d]  = 0;
            end
            for (int i = 7; i > 0; i--) cap[d][i] = cap[d][i-1];
            cap[d][0] = in_v;
        end
        e.so   = cap[d][s-1];
        e.bin  = (br[d] != 0) ? g2b(cap[d][s]) : g2b(cap[d][s-1]);
        e.chg  = (br[d] != 0) ? (cap[d][s] != cap[d][s+1]) : (cap[d][s-1] != cap[d][s]);
        e.gerr = (m_gerr[d] != 0);
        e.cnt  = m_cnt[d];
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check_val("a_sync_out", so_a, e.so);
            check_val("a_sync_bin", bin_a, e.bin);
            check_val("a_ptr_chg", chg_a, e.chg);
            check_val("a_gray_err", gerr_a, e.gerr);
            check_val("a_err_cnt", cnt_a, e.cnt);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check_val("b_sync_out", so_b, e.so);
            check_val("b_sync_bin", bin_b, e.bin);
            check_val("b_ptr_chg", chg_b, e.chg);
            check_val("b_gray_err", gerr_b, e.gerr);
            check_val("b_err_cnt", cnt_b, e.cnt);
        end
        if (count_en && chg_a) pulses_a++;
    endtask

    task automatic drive(input logic [3:0] in_v, input logic clr_v, input logic rst_v);
        exp_t e;
        inp     = in_v;
        err_clr = clr_v;
        rstn    = rst_v;
        model_step(0, in_v, clr_v, rst_v, e);
        q_a.push_back(e);
        model_step(1, in_v, clr_v, rst_v, e);
        q_b.push_back(e);
    endtask

    task automatic run(input logic [3:0] in_v, input logic clr_v, input logic rst_v, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            compare_outputs();
            drive(in_v, clr_v, rst_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] b;
        logic [3:0] g;
        int         hold;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) cap[d][i] = 4'h0;
            m_gerr[d] = 0;
            m_cnt[d]  = 0;
        end
        drive(4'b0101, 1'b0, 1'b0);

        // Reset held with a nonzero pointer, then release on zero
        run(4'b0101, 1'b0, 1'b0, 4);
        run(4'b0000, 1'b0, 1'b1, 4);

        // Single step then the full gray count with wrap 1000 -> 0000
        count_en = 1'b1;
        run(4'b0001, 1'b0, 1'b1, 5);
        for (int v = 2; v < 16; v++) begin
            b = 4'(v);
            run(b ^ (b >> 1), 1'b0, 1'b1, 1 + (v % 2));
        end
        run(4'b0000, 1'b0, 1'b1, 6);
        count_en = 1'b0;
        check_val("a_chg_pulses", pulses_a, 16);
        check_val("a_no_err_after_count", gerr_a, 0);

        // Multi-bit step held: counted once, then saturation of the 2-bit counter
        run(4'b0011, 1'b0, 1'b1, 10);
        check_val("a_cnt_once", cnt_a, 1);
        check_val("b_cnt_once", cnt_b, 1);
        run(4'b0000, 1'b0, 1'b1, 3);
        run(4'b0011, 1'b0, 1'b1, 3);
        run(4'b0000, 1'b0, 1'b1, 3);
        run(4'b0011, 1'b0, 1'b1, 6);
        check_val("a_cnt_sat", cnt_a, 3);
        check_val("b_cnt_five", cnt_b, 5);

        // Clear alone, then clear coincident with a violation on each instance
        run(4'b0011, 1'b1, 1'b1, 1);
        run(4'b0011, 1'b0, 1'b1, 3);
        check_val("a_clr_err", gerr_a, 0);
        check_val("b_clr_cnt", cnt_b, 0);
        run(4'b0000, 1'b0, 1'b1, 2);
        run(4'b0000, 1'b1, 1'b1, 1);
        run(4'b0000, 1'b0, 1'b1, 4);
        check_val("a_clr_viol_cnt", cnt_a, 1);
        run(4'b0011, 1'b0, 1'b1, 4);
        run(4'b0011, 1'b1, 1'b1, 1);
        run(4'b0011, 1'b0, 1'b1, 4);
        check_val("b_clr_viol_cnt", cnt_b, 1);
        check_val("a_clr_late_cnt", cnt_a, 0);

        // Reset mid-stream with 0110 held
        run(4'b0110, 1'b0, 1'b1, 6);
        run(4'b0110, 1'b0, 1'b0, 1);
        #1;
        check_val("b_async_rst_so", so_b, 0);
        check_val("b_async_rst_cnt", cnt_b, 0);
        run(4'b0110, 1'b0, 1'b0, 2);
        run(4'b0110, 1'b0, 1'b1, 8);
        check_val("b_post_rst_so", so_b, 4'b0110);
        check_val("b_post_rst_cnt", cnt_b, 1);

        // Random gray walk with occasional jumps and clears
        run(4'b0110, 1'b1, 1'b1, 1);
        b = g2b(4'b0110);
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = b + 4'd1;
                4, 5, 6:    b = b - 4'd1;
                7:          b = 4'($urandom_range(0, 15));
                default:    ;
            endcase
            g    = b ^ (b >> 1);
            hold = $urandom_range(1, 2);
            run(g, ($urandom_range(0, 7) == 0), 1'b1, hold);
        end
        run(g, 1'b0, 1'b1, 6);

        @(negedge clk);
        compare_outputs();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
